// File: rtl/stack_cmd_sequencer_if.sv
// Request/response handshake between an upstream master and the stack command sequencer.
interface stack_cmd_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int IDX_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic [IDX_W-1:0]  req_index;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_data, req_index,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, req_index,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/stack_cmd_sequencer.sv
// Upstream controller for a small circular stack: checks legality against occupancy,
// issues one stack command per accepted request and returns a single response pulse.
module stack_cmd_sequencer #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 5,
    parameter int IDX_W  = 3,
    parameter int LVL_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    stack_cmd_sequencer_if.slave  req,
    output logic [LVL_W-1:0]      level,
    output logic                  stack_reset,
    output logic [1:0]            command,
    output logic [IDX_W-1:0]      index,
    inout  tri   [DATA_W-1:0]     io_data
);
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_GET  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg, op_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              err_reg, err_next;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic [1:0]        command_reg, command_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic [DATA_W-1:0] resp_data_reg, resp_data_next;
  logic [DATA_W-1:0] capture_reg;
  logic              stack_reset_reg;
  logic              req_legal;
  logic              drive_push;

  always_comb begin
    req_legal = 1'b0;
    case (req.req_op)
      OP_PUSH: req_legal = (int'(level_reg) < DEPTH);
      OP_POP:  req_legal = (level_reg != '0);
      OP_GET:  req_legal = (int'(req.req_index) < int'(level_reg));
      default: req_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    data_next      = data_reg;
    err_next       = err_reg;
    level_next     = level_reg;
    command_next   = command_reg;
    index_next     = index_reg;
    resp_data_next = resp_data_reg;
    case (state_reg)
      IDLE: begin
        // NOP requests are consumed here without generating a response
        if (req.req_valid && req.req_op != OP_NOP) begin
          op_next      = req.req_op;
          data_next    = req.req_data;
          err_next     = !req_legal;
          command_next = req_legal ? req.req_op : OP_NOP;
          index_next   = req_legal ? req.req_index : '0;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        command_next = OP_NOP;
        index_next   = '0;
        state_next   = RESP;
        if (!err_reg) begin
          case (op_reg)
            OP_PUSH: begin
              level_next     = level_reg + LVL_W'(1);
              resp_data_next = data_reg;
            end
            OP_POP: begin
              level_next     = level_reg - LVL_W'(1);
              resp_data_next = capture_reg;
            end
            OP_GET:  resp_data_next = capture_reg;
            default: resp_data_next = resp_data_reg;
          endcase
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_reg        <= OP_NOP;
      data_reg      <= '0;
      err_reg       <= 1'b0;
      level_reg     <= '0;
      command_reg   <= OP_NOP;
      index_reg     <= '0;
      resp_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      data_reg      <= data_next;
      err_reg       <= err_next;
      level_reg     <= level_next;
      command_reg   <= command_next;
      index_reg     <= index_next;
      resp_data_reg <= resp_data_next;
    end
  end

  always_ff @(posedge clk) begin
    stack_reset_reg <= reset;
  end

  // Mid-cycle capture gives the stack half a period to drive its read data
  always_ff @(negedge clk) begin
    if (reset) begin
      capture_reg <= '0;
    end else if (state_reg == ISSUE) begin
      capture_reg <= io_data;
    end
  end

  assign drive_push = (state_reg == ISSUE) && (command_reg == OP_PUSH);

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_io
    assign io_data[gi] = drive_push ? data_reg[gi] : 1'bz;
  end

  assign req.req_ready  = (state_reg == IDLE);
  assign req.resp_valid = (state_reg == RESP);
  assign req.resp_err   = (state_reg == RESP) && err_reg;
  assign req.resp_data  = resp_data_reg;
  assign level          = level_reg;
  assign stack_reset    = stack_reset_reg;
  assign command        = command_reg;
  assign index          = index_reg;
endmodule
